piso_tx: RTL and testbench

Parallel-in, serial-out transmitter. It is the sending end of the serial link that the team's 4-bit serial-in shift registers receive.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per enabled clock, MSB first, with framing flags.
- Bit order matches the receivers: the first bit shifted into a SIPO lands in its MSB, so a SIPO clocked in lockstep recovers the original word.
- Sits between the parallel datapath and the serial line. Supports back-to-back words with no idle gap.

---
 rtl/piso_tx.sv | 91 +++++++++
 tb/tb_piso_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word, shifts it out MSB first with framing flags.
// Latency: MSB on data_out the cycle after the accept edge; done pulses the cycle after the LSB is consumed.
// Backpressure: load_ready only in IDLE or while the last bit is consumed; shift_en low stalls the frame.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             out_valid,
    output logic             last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done_nxt;
    logic             accept;

    assign data_out   = sreg[WIDTH-1];
    assign out_valid  = (state == SHIFT);
    assign last       = (state == SHIFT) && (cnt == CNT_LAST);
    // Ready on the final-bit edge lets the next word follow with no idle gap.
    assign load_ready = (state == IDLE) || (last && shift_en);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = par_in;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (last) begin
                        done_nxt = 1'b1;
                        if (accept) begin
                            sreg_nxt = par_in;
                            cnt_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                            sreg_nxt  = '0;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed frames plus random loopback into a SIPO.
// Stimulus queues expected bits/words on accept; a negedge monitor checks every output cycle.
module tb_piso_tx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] par_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             data_out;
    logic             out_valid;
    logic             last;
    logic             done;

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .last       (last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic l;
    } bit_t;

    bit_t             bitq[$];
    logic [WIDTH-1:0] wordq[$];
    logic [WIDTH-1:0] sipo;
    logic [WIDTH-1:0] acc_word;
    logic             acc;
    logic             done_due;
    logic             mon_en;
    int               mode;
    int               pc;
    int               n_vec;
    int               n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Loopback receiver: first bit in ends up in the MSB.
    always @(posedge clk)
        if (out_valid && shift_en) sipo <= {sipo[WIDTH-2:0], data_out};

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bit_t e;
            e.b = w[i];
            e.l = (i == 0);
            bitq.push_back(e);
        end
        wordq.push_back(w);
    endtask

    // One clock: decide acceptance on settled inputs, then advance and update shift_en.
    task automatic tick();
        #1;
        acc      = load_valid && load_ready && !rst;
        acc_word = par_in;
        @(posedge clk);
        #1;
        if (acc) push_word(acc_word);
        case (mode)
            1: begin
                pc       = (pc + 1) % 3;
                shift_en = (pc == 2);
            end
            2:       shift_en = ($urandom_range(0, 3) != 0);
            default: shift_en = 1'b1;
        endcase
    endtask

    task automatic send(input logic [WIDTH-1:0] w, output int n);
        par_in     = w;
        load_valid = 1'b1;
        n          = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 40);
        load_valid = 1'b0;
        check("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    always @(negedge clk) begin
        logic nxt_due;
        if (mon_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, bitq.size() != 0});
            if (bitq.size() != 0) begin
                check("data_out", {31'd0, data_out}, {31'd0, bitq[0].b});
                check("last", {31'd0, last}, {31'd0, bitq[0].l});
                check("load_ready_busy", {31'd0, load_ready}, {31'd0, bitq[0].l && shift_en});
            end else begin
                check("load_ready_idle", {31'd0, load_ready}, 32'd1);
            end
            check("done", {31'd0, done}, {31'd0, done_due});
            if (done_due && wordq.size() != 0)
                check("loopback", {28'd0, sipo}, {28'd0, wordq.pop_front()});
            nxt_due = 1'b0;
            if (bitq.size() != 0 && shift_en) begin
                nxt_due = bitq[0].l;
                void'(bitq.pop_front());
            end
            if (rst) begin
                bitq.delete();
                wordq.delete();
                nxt_due = 1'b0;
            end
            done_due = nxt_due;
        end
    end

    initial begin
        int n;
        n_vec      = 0;
        n_err      = 0;
        mon_en     = 1'b0;
        done_due   = 1'b0;
        mode       = 0;
        pc         = 0;
        rst        = 1'b1;
        load_valid = 1'b1;
        par_in     = 4'b1111;
        shift_en   = 1'b1;
        sipo       = '0;
        tick();
        tick();

        // Reset state, with load_valid high during reset (must not be accepted).
        @(negedge clk);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, last}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b0;
        rst        = 1'b0;
        mon_en     = 1'b1;
        tick();

        // Basic frame.
        send(4'b1011, n);
        repeat (6) tick();

        // Back-to-back: second word must be taken on the first frame's last-bit cycle.
        send(4'b1011, n);
        send(4'b0110, n);
        check("b2b_accept_cycle", n, 4);
        repeat (7) tick();

        // Pacing: shift_en high every third cycle.
        mode = 1;
        pc   = 0;
        send(4'b1100, n);
        repeat (16) tick();
        mode = 0;
        tick();

        // Busy rejection: 0111 is only taken in cycle 4.
        send(4'b1001, n);
        send(4'b0111, n);
        check("busy_accept_cycle", n, 4);
        repeat (7) tick();

        // Reset in cycle 2 of a frame.
        send(4'b1111, n);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_data_out", {31'd0, data_out}, 32'd0);
        check("abort_load_ready", {31'd0, load_ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        tick();
        send(4'b0101, n);
        repeat (6) tick();

        // Random loopback with random pacing and gaps.
        mode = 2;
        for (int i = 0; i < 50; i++) begin
            send(4'($urandom_range(0, 15)), n);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        mode = 0;
        repeat (12) tick();
        check("queue_drained", bitq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
